lut_eval_pipe: RTL and testbench
================================

LUT_EVAL_PIPE -- requirements
Module: lut_eval_pipe

Interface
REQ-001 SHALL have parameter N_IN, default 4, meaning number of function inputs (1..8).
REQ-002 SHALL have parameter N_OUT, default 13, meaning number of function outputs (1..32).
REQ-003 SHALL have parameter DEPTH, default 2, meaning evaluation pipeline stages (1..4).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port cfg_start  input  1  one-cycle pulse that begins a table load.
REQ-007 SHALL have port cfg_we  input  1  table word write strobe during LOAD.
REQ-008 SHALL have port cfg_data  input  N_OUT  table word; bit k is output f(k+1).
REQ-009 SHALL have port in_valid  input  1  input vector x is valid.
REQ-010 SHALL have port in_ready  output  1  block accepts x this cycle.
REQ-011 SHALL have port x  input  N_IN  input vector; bit i is x(i).
REQ-012 SHALL have port out_valid  output  1  f holds a valid result.
REQ-013 SHALL have port out_ready  input  1  sink accepts f this cycle.
REQ-014 SHALL have port f  output  N_OUT  result vector (N_OUT+1 wide with the parity option).
REQ-015 SHALL have port loaded  output  1  table is complete and block is in RUN.

Function
REQ-016 SHALL hold a table of 2^N_IN words of N_OUT bits; f = table[x].
REQ-017 SHALL implement FSM states IDLE, LOAD, RUN.
REQ-018 IDLE: cfg_start -> LOAD with load pointer cleared to 0; other inputs ignored.
REQ-019 LOAD: each cycle with cfg_we=1 writes cfg_data to table[pointer], pointer increments.
REQ-020 LOAD: write at pointer 2^N_IN-1 -> RUN next cycle; loaded=1 from that cycle.
REQ-021 RUN: cfg_start -> LOAD, pointer=0, all pipeline valid bits cleared same edge, loaded=0.
REQ-022 cfg_start in LOAD SHALL restart the load at pointer 0; a cfg_we in the same cycle is dropped.
REQ-023 in_ready SHALL be 1 only in RUN and when the pipeline is not stalled.
REQ-024 Stall SHALL be out_valid=1 and out_ready=0; while stalled all stages hold.
REQ-025 Accepted x (in_valid & in_ready) SHALL appear on f with out_valid=1 exactly DEPTH cycles later when unstalled.
REQ-026 Results SHALL emerge in acceptance order; none dropped or duplicated under any stall pattern.
REQ-027 Bubbles (in_valid=0) SHALL propagate as invalid stages; throughput one result per cycle.
REQ-028 f SHALL be held stable while out_valid=1 and out_ready=0.
REQ-029 Table contents SHALL persist across RUN->LOAD until overwritten.

Reset
REQ-030 rst=1 SHALL force IDLE, pointer=0, all valid bits 0, in_ready=0, out_valid=0, loaded=0, f=0.
REQ-031 rst mid-LOAD or mid-RUN SHALL abort immediately; table contents are undefined after reset.

Configuration
REQ-032 Macro LUT_EVAL_PARITY_EN SHALL select the parity feature.
REQ-033 With LUT_EVAL_PARITY_EN defined: f is N_OUT+1 bits, f[N_OUT] = XOR of f[N_OUT-1:0], same latency.
REQ-034 Without it: f is N_OUT bits, no parity logic.

Verification
REQ-035 Defaults; load table[a]=3*a; RUN, x=5 in cycle T -> f=15, out_valid=1 at T+2.
REQ-036 Stream x=0..15 back-to-back, out_ready=1 -> f=0,3,..,45 on 16 consecutive cycles.
REQ-037 out_ready=0 for 3 cycles mid-stream -> in_ready=0, f held, no loss, order preserved.
REQ-038 cfg_start in RUN with 2 results in flight -> out_valid=0 next cycle, loaded=0, reload table[a]=a -> x=9 gives f=9.
REQ-039 rst asserted after 7 load writes -> IDLE, loaded=0; then cfg_start + 16 writes -> RUN.
REQ-040 With LUT_EVAL_PARITY_EN, table[3]=0x0007 -> x=3 gives f[12:0]=0x0007, f[13]=1.

Source files
------------

// File: rtl/lut_eval_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : lut_eval_pipe_if
// Brief    : Config, input and result handshake bundle for lut_eval_pipe.
//            f is one bit wider when LUT_EVAL_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface lut_eval_pipe_if #(
   parameter int N_IN  = 4,
   parameter int N_OUT = 13
) ();
`ifdef LUT_EVAL_PARITY_EN
   localparam int c_w_f = N_OUT + 1;
`else
   localparam int c_w_f = N_OUT;
`endif

   logic             cfg_start;
   logic             cfg_we;
   logic [N_OUT-1:0] cfg_data;
   logic             in_valid;
   logic             in_ready;
   logic [N_IN-1:0]  x;
   logic             out_valid;
   logic             out_ready;
   logic [c_w_f-1:0] f;
   logic             loaded;

   modport master (
      output cfg_start, cfg_we, cfg_data, in_valid, x, out_ready,
      input  in_ready, out_valid, f, loaded
   );

   modport slave (
      input  cfg_start, cfg_we, cfg_data, in_valid, x, out_ready,
      output in_ready, out_valid, f, loaded
   );
endinterface
`default_nettype wire

// File: rtl/lut_eval_pipe.sv
`default_nettype none
// ============================================================================
// Module   : lut_eval_pipe
// Brief    : Loadable truth-table evaluator, f = table[x], DEPTH-stage pipeline
//            with valid/ready flow control. Option macro: LUT_EVAL_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module lut_eval_pipe #(
   parameter int N_IN  = 4,
   parameter int N_OUT = 13,
   parameter int DEPTH = 2
) (
   input  wire logic     clk,
   input  wire logic     rst,
   lut_eval_pipe_if.slave bus
);
`ifdef LUT_EVAL_PARITY_EN
   localparam int c_w_f = N_OUT + 1;
`else
   localparam int c_w_f = N_OUT;
`endif
   localparam int              c_n_words  = 1 << N_IN;
   localparam logic [N_IN-1:0] c_ptr_last = '1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2
   } state_t;

   state_t                      r_state;
   logic [N_IN-1:0]             r_ptr;
   logic                        r_loaded;
   logic [N_OUT-1:0]            r_tbl [c_n_words];
   logic [DEPTH-1:0]            r_v;
   logic [DEPTH-1:0][c_w_f-1:0] r_d;

   logic                        w_stall;
   logic                        w_flush;
   logic                        w_tbl_we;
   logic                        w_in_ready;
   logic                        w_accept;
   logic [N_OUT-1:0]            w_word;
   logic [c_w_f-1:0]            w_stage0;

   assign w_stall    = r_v[DEPTH-1] & ~bus.out_ready;
   assign w_flush    = (r_state == S_RUN) & bus.cfg_start;
   // A write coinciding with a load restart is discarded.
   assign w_tbl_we   = (r_state == S_LOAD) & bus.cfg_we & ~bus.cfg_start;
   assign w_in_ready = (r_state == S_RUN) & ~w_stall;
   assign w_accept   = bus.in_valid & w_in_ready;
   assign w_word     = r_tbl[bus.x];

`ifdef LUT_EVAL_PARITY_EN
   assign w_stage0 = {^w_word, w_word};
`else
   assign w_stage0 = w_word;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_ptr    <= '0;
         r_loaded <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.cfg_start) begin
                  r_state <= S_LOAD;
                  r_ptr   <= '0;
               end
            end
            S_LOAD: begin
               if (bus.cfg_start) begin
                  r_ptr <= '0;
               end else if (bus.cfg_we) begin
                  r_ptr <= r_ptr + 1'b1;
                  if (r_ptr == c_ptr_last) begin
                     r_state  <= S_RUN;
                     r_loaded <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (bus.cfg_start) begin
                  r_state  <= S_LOAD;
                  r_ptr    <= '0;
                  r_loaded <= 1'b0;
               end
            end
            default: begin
               r_state  <= S_IDLE;
               r_ptr    <= '0;
               r_loaded <= 1'b0;
            end
         endcase
      end
   end

   // Table storage carries no reset; contents are undefined until reloaded.
   always_ff @(posedge clk) begin
      if (w_tbl_we) begin
         r_tbl[r_ptr] <= bus.cfg_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v <= '0;
         r_d <= '0;
      end else if (w_flush) begin
         r_v <= '0;
      end else if (!w_stall) begin
         r_v[0] <= w_accept;
         if (w_accept) begin
            r_d[0] <= w_stage0;
         end
         for (int i = 1; i < DEPTH; i++) begin
            r_v[i] <= r_v[i-1];
            r_d[i] <= r_d[i-1];
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_v[DEPTH-1];
   assign bus.f         = r_d[DEPTH-1];
   assign bus.loaded    = r_loaded;

endmodule
`default_nettype wire

// File: tb/tb_lut_eval_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_lut_eval_pipe
// Brief    : Self-checking bench for lut_eval_pipe: vector table, hand-written
//            corner sequences and a randomized stream against a table model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lut_eval_pipe;
   localparam int N_IN  = 4;
   localparam int N_OUT = 13;
   localparam int DEPTH = 2;
`ifdef LUT_EVAL_PARITY_EN
   localparam int W_F = N_OUT + 1;
`else
   localparam int W_F = N_OUT;
`endif

   logic clk;
   logic rst;

   lut_eval_pipe_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus ();

   lut_eval_pipe #(.N_IN(N_IN), .N_OUT(N_OUT), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [N_IN-1:0] x;
      logic [W_F-1:0]  exp_f;
   } vec_t;

   int               n_chk = 0;
   int               n_fail = 0;
   logic [N_OUT-1:0] tbl_m   [16];
   logic [N_OUT-1:0] tbl_new [16];
   logic [W_F-1:0]   exp_q [$];
   bit               m_run = 1'b0;
   bit               held_valid = 1'b0;
   logic [W_F-1:0]   held_f;
   int               t_now = 0;
   int               acc_n, pop_n, acc_first, pop_first, pop_last;
   vec_t             vecs [6];

   // Reference: f is the table word, plus even-parity bit when enabled.
   function automatic logic [W_F-1:0] exp_of(input logic [N_OUT-1:0] w);
`ifdef LUT_EVAL_PARITY_EN
      return {^w, w};
`else
      return w;
`endif
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic stats_clear();
      acc_n = 0; pop_n = 0; acc_first = -1; pop_first = -1; pop_last = -1;
   endtask

   // One streaming cycle: check handshake, hold and ordering, then advance.
   task automatic tick(output bit acc);
      logic exp_rdy;
      #1;
      exp_rdy = m_run && !(bus.out_valid && !bus.out_ready);
      chk("in_ready", bus.in_ready, exp_rdy);
      if (held_valid) chk("stall_hold", {bus.out_valid, bus.f}, {1'b1, held_f});
      held_valid = bus.out_valid && !bus.out_ready;
      held_f     = bus.f;
      if (bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) chk("spurious_out", 1, 0);
         else chk("stream_f", bus.f, exp_q.pop_front());
         if (pop_first < 0) pop_first = t_now;
         pop_last = t_now;
         pop_n++;
      end
      acc = bus.in_valid && bus.in_ready;
      if (acc) begin
         exp_q.push_back(exp_of(tbl_m[bus.x]));
         if (acc_first < 0) acc_first = t_now;
         acc_n++;
      end
      t_now++;
      step();
   endtask

   task automatic load_table(input bit do_start);
      bus.in_valid = 1'b0;
      bus.cfg_we   = 1'b0;
      if (do_start) begin
         bus.cfg_start = 1'b1;
         step();
         bus.cfg_start = 1'b0;
      end
      m_run = 1'b0;
      for (int a = 0; a < 16; a++) begin
         bus.cfg_we   = 1'b1;
         bus.cfg_data = tbl_new[a];
         #1 chk("loaded_low_during_load", bus.loaded, 0);
         step();
      end
      bus.cfg_we = 1'b0;
      #1;
      chk("loaded_after_load", bus.loaded, 1);
      chk("in_ready_after_load", bus.in_ready, 1);
      tbl_m = tbl_new;
      m_run = 1'b1;
   endtask

   task automatic run_vec(input logic [N_IN-1:0] xv, input logic [W_F-1:0] ef);
      bus.x         = xv;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      #1 chk("vec_accept", bus.in_ready, 1);
      step();
      bus.in_valid = 1'b0;
      chk("vec_not_early", bus.out_valid, 0);
      step();
      chk("vec_valid_at_depth", bus.out_valid, 1);
      chk("vec_f", bus.f, ef);
      step();
   endtask

   task automatic drain();
      bit acc;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 20 && (exp_q.size() != 0 || bus.out_valid); i++) tick(acc);
      chk("drain_queue_empty", exp_q.size(), 0);
      chk("drain_out_valid", bus.out_valid, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      bit acc;
      int k;

      vecs[0] = '{4'd5,  exp_of(13'd15)};
      vecs[1] = '{4'd0,  exp_of(13'd0)};
      vecs[2] = '{4'd15, exp_of(13'd45)};
      vecs[3] = '{4'd7,  exp_of(13'd21)};
      vecs[4] = '{4'd10, exp_of(13'd30)};
      vecs[5] = '{4'd1,  exp_of(13'd3)};

      rst = 1'b1;
      bus.cfg_start = 1'b0; bus.cfg_we = 1'b0; bus.cfg_data = '0;
      bus.in_valid  = 1'b0; bus.x = '0; bus.out_ready = 1'b1;
      step(); step();
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_loaded", bus.loaded, 0);
      chk("rst_f", bus.f, 0);
      rst = 1'b0;
      step();
      chk("idle_in_ready", bus.in_ready, 0);

      // table[a] = 3*a and single-shot latency vectors
      for (int a = 0; a < 16; a++) tbl_new[a] = N_OUT'(3 * a);
      load_table(1'b1);
      foreach (vecs[i]) run_vec(vecs[i].x, vecs[i].exp_f);

      // back-to-back 0..15
      stats_clear();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         bus.x = N_IN'(i); bus.in_valid = 1'b1;
         tick(acc);
      end
      bus.in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick(acc);
      chk("b2b_accepts", acc_n, 16);
      chk("b2b_results", pop_n, 16);
      chk("b2b_latency", pop_first - acc_first, DEPTH);
      chk("b2b_consecutive", pop_last - pop_first, 15);

      // 3-cycle sink stall mid-stream
      k = 0;
      for (int t = 0; t < 30 && k < 8; t++) begin
         bus.x = N_IN'(k + 3); bus.in_valid = 1'b1;
         bus.out_ready = !(t >= 3 && t <= 5);
         tick(acc);
         if (acc) k++;
      end
      chk("stall_all_accepted", k, 8);
      drain();

      // randomized stream
      for (int t = 0; t < 300; t++) begin
         bus.x         = N_IN'($urandom);
         bus.in_valid  = ($urandom_range(3, 0) != 0);
         bus.out_ready = ($urandom_range(2, 0) != 0);
         tick(acc);
      end
      drain();

      // reload from RUN with two results in flight
      bus.out_ready = 1'b1; bus.in_valid = 1'b1;
      bus.x = 4'd2;  tick(acc);
      bus.x = 4'd11; tick(acc);
      bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.cfg_start = 1'b1;
      #1 chk("pre_flush_out_valid", bus.out_valid, 1);
      step();
      bus.cfg_start = 1'b0;
      m_run = 1'b0; exp_q.delete(); held_valid = 1'b0;
      chk("flush_out_valid", bus.out_valid, 0);
      chk("flush_loaded", bus.loaded, 0);
      chk("flush_in_ready", bus.in_ready, 0);
      for (int a = 0; a < 16; a++) tbl_new[a] = N_OUT'(a);
      load_table(1'b0);
      run_vec(4'd9, exp_of(13'd9));
      chk("flush_no_ghost", bus.out_valid, 0);

      // restart mid-load, with a simultaneous write that must be dropped
      bus.cfg_start = 1'b1; step(); bus.cfg_start = 1'b0;
      m_run = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.cfg_we = 1'b1; bus.cfg_data = N_OUT'($urandom); step();
      end
      bus.cfg_start = 1'b1; bus.cfg_we = 1'b1; bus.cfg_data = N_OUT'($urandom);
      step();
      bus.cfg_start = 1'b0;
      for (int a = 0; a < 16; a++) tbl_new[a] = N_OUT'($urandom);
      load_table(1'b0);
      for (int t = 0; t < 40; t++) begin
         bus.x = N_IN'(t); bus.in_valid = 1'b1; bus.out_ready = ($urandom_range(3, 0) != 0);
         tick(acc);
      end
      drain();

      // reset after 7 load writes, then a full load
      bus.cfg_start = 1'b1; step(); bus.cfg_start = 1'b0;
      m_run = 1'b0;
      for (int i = 0; i < 7; i++) begin
         bus.cfg_we = 1'b1; bus.cfg_data = N_OUT'(i); step();
      end
      bus.cfg_we = 1'b0;
      rst = 1'b1;
      #1;
      chk("async_rst_loaded", bus.loaded, 0);
      chk("async_rst_in_ready", bus.in_ready, 0);
      chk("async_rst_out_valid", bus.out_valid, 0);
      step();
      rst = 1'b0; exp_q.delete(); held_valid = 1'b0;
      step();
      chk("post_rst_idle_in_ready", bus.in_ready, 0);
      for (int a = 0; a < 16; a++) tbl_new[a] = (a == 3) ? 13'h0007 : N_OUT'($urandom);
      load_table(1'b1);
      run_vec(4'd3, exp_of(13'h0007));
      for (int t = 0; t < 60; t++) begin
         bus.x         = N_IN'($urandom);
         bus.in_valid  = ($urandom_range(1, 0) != 0);
         bus.out_ready = ($urandom_range(3, 0) != 0);
         tick(acc);
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
